updown_timer: RTL
=================

# updown_timer

Parametrised up/down counter-timer with load, compare value, four counting modes and an IDLE/RUN/DONE control FSM. Generalises the team's 8-bit up/down counter with compare-clear: width is configurable, counting is gated by a start/stop handshake, and one-shot, saturating and free-running behaviour are added. It sits beside the comparator and datapath blocks as the common timebase and event counter.

## Interface
- WIDTH, 8, counter and compare width (>=2)
- PRESC_W, 4, prescaler divider width (used only with prescaler compiled in)
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  begin counting (IDLE/DONE -> RUN)
- stop  in  1  abort counting (any state -> IDLE)
- up_down  in  1  1 = count up, 0 = count down
- load  in  1  write load_data into count
- load_data  in  WIDTH  value written on load
- cmp_val  in  WIDTH  compare value
- mode  in  2  00 FREE, 01 CLEAR, 10 ONESHOT, 11 SAT
- presc_div  in  PRESC_W  tick every presc_div+1 cycles
- count  out  WIDTH  current count, registered
- match  out  1  combinational, count == cmp_val
- wrap  out  1  registered one-cycle pulse on wrap/clear
- busy  out  1  state == RUN
- done  out  1  state == DONE

## Operation
- FSM: IDLE --start--> RUN; RUN --ONESHOT terminal--> DONE; DONE --start--> RUN; any --stop--> IDLE; DONE --load--> IDLE.
- Priority per edge: rst > load > stop > start > tick action.
- start while in RUN is ignored. start does not modify count; software loads first.
- Counting happens only in RUN and only on a tick. On each tick:
  - FREE: count +/- 1 modulo 2^WIDTH; wrap pulses when the step crosses max->0 (up) or 0->max (down).
  - CLEAR: if count == cmp_val then count <= 0 and wrap pulses, regardless of direction; else step modulo 2^WIDTH.
  - ONESHOT: if count == cmp_val then state <= DONE and count holds; else step modulo 2^WIDTH.
  - SAT: step, except hold at 2^WIDTH-1 (up) or 0 (down); wrap never pulses.
- load: count <= load_data in any state; prescaler cleared; RUN stays RUN, DONE goes to IDLE.
- IDLE and DONE: count holds.
- mode and up_down are sampled on every tick and must be held stable during RUN; a change applies from the next tick.
- match is valid in every state and is not qualified by busy.

## Timing
- Reset values: count 0, state IDLE, busy 0, done 0, wrap 0; match = (cmp_val == 0).
- start sampled at edge N: busy = 1 after N. First tick is at edge N+1 without the prescaler, or edge N+presc_div+1 with it.
- Each tick changes count one cycle later; wrap is high for exactly the cycle after the wrapping edge.
- CLEAR with tick every cycle: count reads cmp_val for exactly one cycle, then 0.
- ONESHOT: done = 1 after the tick edge that finds count == cmp_val. If count already equals cmp_val at start, DONE follows the first tick.
- stop and start in the same cycle: IDLE. load and a tick in the same cycle: load wins and no step occurs.
- rst mid-RUN returns all outputs to their reset values at that edge.

## Configuration
- UPDOWN_TIMER_PRESCALE_EN defined: a PRESC_W-bit prescaler counter runs only in RUN.
  - It is cleared on rst, start, stop, load, and on reaching presc_div.
  - tick = (presc_cnt == presc_div).
- Not defined: tick = 1 every RUN cycle, presc_div is ignored and no prescaler flops exist.

## Structure
- Package updown_timer_pkg:
  - mode encodings MODE_FREE/MODE_CLEAR/MODE_ONESHOT/MODE_SAT;
  - FSM state typedef (ST_IDLE, ST_RUN, ST_DONE).
- One sub-module: tick_prescaler (PRESC_W, clk, rst, clr, run, div -> tick), instantiated only under UPDOWN_TIMER_PRESCALE_EN.
- Top level holds the FSM, the next-count mux (load / clear / step / saturate / hold), and the wrap register.

## Test plan
- WIDTH=8, FREE, up, load 0xFE, start, no prescaler -> count 0xFF, 0x00 (wrap=1 one cycle), 0x01.
- CLEAR, up, cmp_val=5, from 0 -> count 0,1,2,3,4,5,0 repeating; wrap pulses after each 5->0; match high while count=5.
- ONESHOT, down, load 3, cmp_val=0, start -> 3,2,1,0; done=1, busy=0, count holds 0; a second start returns to DONE after one tick.
- SAT, up, load 0xFD -> 0xFE, 0xFF, 0xFF...; wrap stays 0. Down from 0x01 -> 0x00 and holds.
- Priority: load=1 with a tick -> count=load_data and no step. stop+start together -> IDLE. rst mid-RUN -> count 0, busy 0 the next cycle.
- Prescaler (UPDOWN_TIMER_PRESCALE_EN), presc_div=3, FREE up from 0 -> count increments every 4 cycles. First increment is at edge start+4.

Source files
------------

// File: rtl/updown_timer_pkg.sv
// Shared encodings for the up/down counter-timer: counting modes and control FSM states.
package updown_timer_pkg;

  typedef enum logic [1:0] {
    MODE_FREE    = 2'b00,
    MODE_CLEAR   = 2'b01,
    MODE_ONESHOT = 2'b10,
    MODE_SAT     = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/updown_timer_tick_prescaler.sv
// Tick divider: emits one tick every div_i+1 cycles while run_i is high.
module tick_prescaler #(
  parameter int PRESC_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr_i,
  input  logic               run_i,
  input  logic [PRESC_W-1:0] div_i,
  output logic               tick_o
);

  logic [PRESC_W-1:0] cnt_q, cnt_d;

  assign tick_o = run_i && (cnt_q == div_i);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)       cnt_d = '0;
    else if (tick_o) cnt_d = '0;
    else if (run_i)  cnt_d = cnt_q + PRESC_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/updown_timer.sv
// Up/down counter-timer with load, compare and FREE/CLEAR/ONESHOT/SAT modes.
// Define UPDOWN_TIMER_PRESCALE_EN to insert the tick prescaler.
import updown_timer_pkg::*;

module updown_timer #(
  parameter int WIDTH   = 8,
  parameter int PRESC_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               stop_i,
  input  logic               up_down_i,
  input  logic               load_i,
  input  logic [WIDTH-1:0]   load_data_i,
  input  logic [WIDTH-1:0]   cmp_val_i,
  input  logic [1:0]         mode_i,
  input  logic [PRESC_W-1:0] presc_div_i,
  output logic [WIDTH-1:0]   count_o,
  output logic               match_o,
  output logic               wrap_o,
  output logic               busy_o,
  output logic               done_o
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             busy_q, done_q;

  logic             run_en, start_go, tick, at_end;
  logic [WIDTH-1:0] step;
  mode_e            mode;

  assign run_en   = (state_q == ST_RUN);
  assign start_go = start_i && !run_en;
  assign mode     = mode_e'(mode_i);
  assign step     = up_down_i ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
  // Edge of the range in the current direction: wrap point for FREE, hold point for SAT.
  assign at_end   = up_down_i ? (&count_q) : ~(|count_q);

`ifdef UPDOWN_TIMER_PRESCALE_EN
  tick_prescaler #(.PRESC_W(PRESC_W)) u_presc (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (load_i | stop_i | start_go),
    .run_i  (run_en),
    .div_i  (presc_div_i),
    .tick_o (tick)
  );
`else
  logic unused_presc;
  assign unused_presc = ^presc_div_i;
  assign tick         = run_en;
`endif

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    wrap_d  = 1'b0;
    if (load_i) begin
      count_d = load_data_i;
      if (state_q == ST_DONE) state_d = ST_IDLE;
    end else if (stop_i) begin
      state_d = ST_IDLE;
    end else if (start_go) begin
      state_d = ST_RUN;
    end else if (tick) begin
      case (mode)
        MODE_FREE: begin
          count_d = step;
          wrap_d  = at_end;
        end
        MODE_CLEAR: begin
          if (match_o) begin
            count_d = '0;
            wrap_d  = 1'b1;
          end else begin
            count_d = step;
          end
        end
        MODE_ONESHOT: begin
          if (match_o) state_d = ST_DONE;
          else         count_d = step;
        end
        MODE_SAT: begin
          if (!at_end) count_d = step;
        end
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      wrap_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      wrap_q  <= wrap_d;
      busy_q  <= (state_d == ST_RUN);
      done_q  <= (state_d == ST_DONE);
    end
  end

  assign count_o = count_q;
  assign match_o = (count_q == cmp_val_i);
  assign wrap_o  = wrap_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;

endmodule
